z_core_alu_arbiter: RTL and testbench
=====================================

# z_core_alu_arbiter

Shares the core's single combinational ALU (`z_core_alu`) between two requesters, e.g. the integer execute path and the branch-compare path. The block arbitrates round-robin and registers the result with a requester ID. It presents results on one valid/ready response channel and keeps saturating per-requester grant counters for performance monitoring. It sits between the decode/issue logic and writeback/branch resolution.

## Interface
- `CNT_W`, default 16: width of each grant counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_in1` in 32: requester 0 operand 1.
- `req0_in2` in 32: requester 0 operand 2.
- `req0_op` in 4: requester 0 ALU op code (0–15, ALU encoding).
- `req1_valid`, `req1_ready`, `req1_in1`, `req1_in2`, `req1_op`: same as above, for requester 1.
- `res_valid` out 1: result register holds an unconsumed result.
- `res_ready` in 1: consumer accepts the result.
- `res_id` out 1: requester that owns the result.
- `res_out` out 32: ALU data result.
- `res_branch` out 1: ALU branch-taken flag.
- `grant_cnt0` out CNT_W: saturating count of requester 0 acceptances.
- `grant_cnt1` out CNT_W: saturating count of requester 1 acceptances.

## Operation
- **Internal ALU:** one `z_core_alu` instance. Its inputs come from a mux that selects the granted requester's in1/in2/op.
- **Capacity:** `can_accept = !res_valid || res_ready`.
- **Arbitration:** a 1-bit `prio` register, reset value 0.
  - Both valid: grant `prio`.
  - One valid: grant that requester.
  - None valid: no grant.
- **Ready outputs:** `reqN_ready = can_accept && grantN`. At most one `reqN_ready` is high per cycle. Ready may depend combinationally on valid.
- **Handshake:** a handshake on requester N happens when `reqN_valid && reqN_ready`. At that edge:
  - `res_out` and `res_branch` capture the ALU outputs.
  - `res_id` captures N.
  - `res_valid` is set to 1.
  - `prio` becomes `!N`.
  - `grant_cntN` increments, unless it is already all-ones, in which case it holds.
- **Result consumption:** `res_valid && res_ready` with no new handshake clears `res_valid`. Consumption and a new handshake in the same cycle: `res_valid` stays 1 and the new result replaces the old one (back-to-back throughput of 1 op/cycle).
- **Result hold:** while `res_valid && !res_ready`, `res_out`, `res_branch` and `res_id` are held stable and no request is accepted.
- **Requester obligations:** once `reqN_valid` is high, operands and op are held until ready. The block does not check this.
- **Branch ops (op 10–15):** `res_out` = 0 and `res_branch` carries the compare.
- **ALU ops (op 0–9):** `res_branch` = 0.
- **Starvation freedom:** with both requesters continuously valid and `res_ready` = 1, grants strictly alternate 0,1,0,1…

## Timing
- **Reset values (asynchronous):** `res_valid` 0, `res_id` 0, `res_out` 0, `res_branch` 0, `prio` 0, `grant_cnt0` 0, `grant_cnt1` 0. `reqN_ready` evaluates from these values.
- **Latency:** a request accepted at edge E has its result visible with `res_valid` = 1 in the cycle after E.
- **Throughput:** 1 result per cycle when `res_ready` is held high.
- **Reset mid-operation:** an unconsumed result is discarded with no response. Counters and `prio` restart from their reset values.
- **Counter boundary:** at all-ones the counter holds; it never wraps to 0.
- **No combinational path from `res_ready`** to any output other than `reqN_ready`.

## Test plan
- **Reset:** assert `rst` mid-cycle with `res_valid` = 1 → all outputs go to their reset values immediately, and `req0_ready` = 1 the next cycle when `req0_valid` = 1.
- **Single ADD:** req0 in1=5, in2=7, op=0, `res_ready` = 1 → next cycle `res_valid` = 1, `res_out` = 12, `res_id` = 0, `res_branch` = 0, `grant_cnt0` = 1.
- **Contention:** both requesters valid for 4 cycles, req0 SUB 10−3 and req1 BLT (in1=0xFFFFFFFF, in2=1) → grants in order 0,1,0,1. Results are `res_out` = 7 with id 0, and `res_branch` = 1 with id 1.
- **Backpressure:** `res_ready` = 0 for 3 cycles holding `res_out` = 0x80000000 from SRA (in1=0x80000000, in2=0) → `res_out` is stable and both `reqN_ready` = 0. When `res_ready` goes to 1, the new request is accepted in that same cycle.
- **Saturation:** `CNT_W` = 2, 5 consecutive req1 grants → `grant_cnt1` reads 1,2,3,3,3.
- **Back-to-back:** req0 XOR ops continuously, with `res_ready` = 1 → `res_valid` stays 1 and a new result appears every cycle.

Source files
------------

// File: rtl/z_core_alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the arbiter and the result consumer.
// No latency of its own; it only groups wires.
// Ready/valid on both request channels and on the single response channel.
interface z_core_alu_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_in1;
    logic [31:0]      req0_in2;
    logic [3:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_in1;
    logic [31:0]      req1_in2;
    logic [3:0]       req1_op;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [31:0]      res_out;
    logic             res_branch;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    // Requesters plus result consumer side.
    modport master (
        output req0_valid, req0_in1, req0_in2, req0_op,
        output req1_valid, req1_in1, req1_in2, req1_op,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_out, res_branch,
        input  grant_cnt0, grant_cnt1
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_op,
        input  req1_valid, req1_in1, req1_in2, req1_op,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_out, res_branch,
        output grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/z_core_alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with saturating grant counters.
// Latency: result registered, visible with res_valid the cycle after acceptance; 1 op/cycle throughput.
// Backpressure: while res_valid && !res_ready the result is held and neither requester is accepted.

// Combinational core ALU.
// Encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND,
//           10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU (branches drive out = 0).
module z_core_alu (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  op,
    output logic [31:0] out,
    output logic        branch
);
    logic [4:0] shamt;
    assign shamt = in2[4:0];

    // Data result and branch compare for the selected op.
    always_comb begin
        out    = '0;
        branch = 1'b0;
        case (op)
            4'd0:  out = in1 + in2;
            4'd1:  out = in1 - in2;
            4'd2:  out = in1 << shamt;
            4'd3:  out = {31'b0, $signed(in1) < $signed(in2)};
            4'd4:  out = {31'b0, in1 < in2};
            4'd5:  out = in1 ^ in2;
            4'd6:  out = in1 >> shamt;
            4'd7:  out = $signed(in1) >>> shamt;
            4'd8:  out = in1 | in2;
            4'd9:  out = in1 & in2;
            4'd10: branch = (in1 == in2);
            4'd11: branch = (in1 != in2);
            4'd12: branch = ($signed(in1) <  $signed(in2));
            4'd13: branch = ($signed(in1) >= $signed(in2));
            4'd14: branch = (in1 <  in2);
            default: branch = (in1 >= in2);
        endcase
    end
endmodule

module z_core_alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    z_core_alu_arbiter_if.slave  bus
);
    logic             prio;
    logic             res_valid;
    logic             res_id;
    logic [31:0]      res_out;
    logic             res_branch;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             hs0;
    logic             hs1;
    logic [31:0]      alu_in1;
    logic [31:0]      alu_in2;
    logic [3:0]       alu_op;
    logic [31:0]      alu_out;
    logic             alu_branch;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A new result may be written when the slot is empty or is being drained this cycle.
    assign can_accept = !res_valid || bus.res_ready;

    // Contention goes to prio; a lone requester always wins.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
    assign grant1 = bus.req1_valid && (!bus.req0_valid ||  prio);

    assign bus.req0_ready = can_accept && grant0;
    assign bus.req1_ready = can_accept && grant1;

    assign hs0 = bus.req0_valid && bus.req0_ready;
    assign hs1 = bus.req1_valid && bus.req1_ready;

    // Operand mux feeding the shared ALU.
    assign alu_in1 = grant1 ? bus.req1_in1 : bus.req0_in1;
    assign alu_in2 = grant1 ? bus.req1_in2 : bus.req0_in2;
    assign alu_op  = grant1 ? bus.req1_op  : bus.req0_op;

    z_core_alu u_alu (
        .in1    (alu_in1),
        .in2    (alu_in2),
        .op     (alu_op),
        .out    (alu_out),
        .branch (alu_branch)
    );

    // Result register: load on any handshake, clear when drained without a replacement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            res_out    <= '0;
            res_branch <= 1'b0;
            prio       <= 1'b0;
        end else if (hs0 || hs1) begin
            res_valid  <= 1'b1;
            res_id     <= hs1;
            res_out    <= alu_out;
            res_branch <= alu_branch;
            prio       <= !hs1;
        end else if (bus.res_ready) begin
            res_valid  <= 1'b0;
        end
    end

    // Saturating per-requester acceptance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (hs0 && cnt0 != '1) cnt0 <= cnt0 + CNT_ONE;
            if (hs1 && cnt1 != '1) cnt1 <= cnt1 + CNT_ONE;
        end
    end

    assign bus.res_valid  = res_valid;
    assign bus.res_id     = res_id;
    assign bus.res_out    = res_out;
    assign bus.res_branch = res_branch;
    assign bus.grant_cnt0 = cnt0;
    assign bus.grant_cnt1 = cnt1;
endmodule

// File: tb/tb_z_core_alu_arbiter.sv
// Directed bench for z_core_alu_arbiter: reset, ADD, contention, backpressure, back-to-back,
// mid-operation reset, and counter saturation on a second instance with a 2-bit counter.
module tb_z_core_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    z_core_alu_arbiter_if #(.CNT_W(16)) bus ();
    z_core_alu_arbiter_if #(.CNT_W(2))  bus2 ();

    z_core_alu_arbiter #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    z_core_alu_arbiter #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req0_valid = 0; bus.req0_in1 = 0; bus.req0_in2 = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_in1 = 0; bus.req1_in2 = 0; bus.req1_op = 0;
        bus.res_ready  = 0;
        bus2.req0_valid = 0; bus2.req0_in1 = 0; bus2.req0_in2 = 0; bus2.req0_op = 0;
        bus2.req1_valid = 0; bus2.req1_in1 = 0; bus2.req1_in2 = 0; bus2.req1_op = 0;
        bus2.res_ready  = 0;

        tick(); tick();
        rst = 1'b0;
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_res_out", bus.res_out, 0);
        chk("rst_res_branch", bus.res_branch, 0);
        chk("rst_cnt0", bus.grant_cnt0, 0);
        chk("rst_cnt1", bus.grant_cnt1, 0);
        chk("idle_ready0", bus.req0_ready, 0);

        // Single ADD 5+7 from requester 0
        bus.req0_valid = 1; bus.req0_in1 = 5; bus.req0_in2 = 7; bus.req0_op = 4'd0;
        bus.res_ready = 1;
        #1;
        chk("add_ready0", bus.req0_ready, 1);
        chk("add_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 0;
        chk("add_valid", bus.res_valid, 1);
        chk("add_out", bus.res_out, 12);
        chk("add_id", bus.res_id, 0);
        chk("add_branch", bus.res_branch, 0);
        chk("add_cnt0", bus.grant_cnt0, 1);

        // BEQ 4,4 from requester 1 (branch op: out forced to 0); also hands prio back to 0
        bus.req1_valid = 1; bus.req1_in1 = 4; bus.req1_in2 = 4; bus.req1_op = 4'd10;
        #1;
        chk("beq_ready1", bus.req1_ready, 1);
        tick();
        chk("beq_out", bus.res_out, 0);
        chk("beq_branch", bus.res_branch, 1);
        chk("beq_id", bus.res_id, 1);
        chk("beq_cnt1", bus.grant_cnt1, 1);

        // Contention: req0 SUB 10-3, req1 BLT -1<1; grants alternate 0,1,0,1
        bus.req0_valid = 1; bus.req0_in1 = 10; bus.req0_in2 = 3; bus.req0_op = 4'd1;
        bus.req1_valid = 1; bus.req1_in1 = 32'hFFFF_FFFF; bus.req1_in2 = 1; bus.req1_op = 4'd12;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready0", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("cont_ready1", bus.req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            chk("cont_id", bus.res_id, (i % 2 == 1) ? 1 : 0);
            chk("cont_out", bus.res_out, (i % 2 == 1) ? 0 : 7);
            chk("cont_branch", bus.res_branch, (i % 2 == 1) ? 1 : 0);
        end
        chk("cont_cnt0", bus.grant_cnt0, 3);
        chk("cont_cnt1", bus.grant_cnt1, 3);
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();
        chk("drain_valid", bus.res_valid, 0);

        // Backpressure: SRA 0x80000000>>>0 then hold with res_ready low
        bus.req0_valid = 1; bus.req0_in1 = 32'h8000_0000; bus.req0_in2 = 0; bus.req0_op = 4'd7;
        bus.res_ready = 0;
        #1;
        chk("sra_ready0", bus.req0_ready, 1);
        tick();
        chk("sra_out", bus.res_out, 32'h8000_0000);
        bus.req0_in1 = 1; bus.req0_in2 = 2; bus.req0_op = 4'd0;
        bus.req1_valid = 1; bus.req1_in1 = 32'hF0; bus.req1_in2 = 32'h3C; bus.req1_op = 4'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
            tick();
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_out", bus.res_out, 32'h8000_0000);
            chk("bp_id", bus.res_id, 0);
        end
        bus.res_ready = 1;
        #1;
        chk("rel_ready1", bus.req1_ready, 1);
        chk("rel_ready0", bus.req0_ready, 0);
        tick();
        chk("rel_out", bus.res_out, 32'h30);
        chk("rel_id", bus.res_id, 1);
        bus.req1_valid = 0;
        #1;
        chk("rel2_ready0", bus.req0_ready, 1);
        tick();
        chk("rel2_out", bus.res_out, 3);
        chk("rel2_id", bus.res_id, 0);
        chk("bp_cnt0", bus.grant_cnt0, 5);
        chk("bp_cnt1", bus.grant_cnt1, 4);

        // Back-to-back XOR from requester 0
        bus.req0_op = 4'd5; bus.req0_in2 = 32'h0000_FFFF;
        for (int i = 0; i < 4; i++) begin
            bus.req0_in1 = 32'h1234_0000 + i;
            tick();
            chk("b2b_valid", bus.res_valid, 1);
            chk("b2b_out", bus.res_out, 32'h1234_FFFF - i);
        end
        chk("b2b_cnt0", bus.grant_cnt0, 9);

        // Reset mid-cycle with an unconsumed result
        bus.req0_valid = 0; bus.res_ready = 0;
        tick();
        chk("pre_rst_valid", bus.res_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("mrst_valid", bus.res_valid, 0);
        chk("mrst_out", bus.res_out, 0);
        chk("mrst_id", bus.res_id, 0);
        chk("mrst_cnt0", bus.grant_cnt0, 0);
        chk("mrst_cnt1", bus.grant_cnt1, 0);
        #1 rst = 1'b0;
        bus.req0_valid = 1; bus.req0_in1 = 5; bus.req0_in2 = 7; bus.req0_op = 4'd0;
        bus.req1_valid = 1;
        #1;
        chk("mrst_ready0", bus.req0_ready, 1);
        chk("mrst_ready1", bus.req1_ready, 0);
        tick();
        chk("mrst_out2", bus.res_out, 12);
        chk("mrst_cnt0b", bus.grant_cnt0, 1);
        bus.req0_valid = 0; bus.req1_valid = 0;

        // Saturation on the 2-bit counter instance
        bus2.req1_valid = 1; bus2.req1_in1 = 1; bus2.req1_in2 = 1; bus2.req1_op = 4'd0;
        bus2.res_ready = 1;
        begin
            int sat_exp[5] = '{1, 2, 3, 3, 3};
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("sat_cnt1", {30'b0, bus2.grant_cnt1}, sat_exp[i]);
            end
        end
        chk("sat_out", bus2.res_out, 2);
        bus2.req1_valid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
